// File: rtl/regfile_mp_if.sv
// Bundle of regfile_mp read, write, issue and soft-clear signals.
// The master drives the in_* side; the slave (the register file) drives the out_* side.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  logic [NRD-1:0]        in_rd_ena;
  logic [NRD*ADDR_W-1:0] in_rd_addr;
  logic [NWR-1:0]        in_wr_ena;
  logic [NWR*ADDR_W-1:0] in_wr_addr;
  logic [NWR*DATA_W-1:0] in_wr_data;
  logic                  in_iss_ena;
  logic [ADDR_W-1:0]     in_iss_addr;
  logic                  in_clr_req;
  logic [NRD*DATA_W-1:0] out_rd_data;
  logic [NRD-1:0]        out_rd_busy;
  logic                  out_clr_busy;
  logic                  out_clr_done;

  modport master (
    output in_rd_ena, in_rd_addr, in_wr_ena, in_wr_addr, in_wr_data,
    output in_iss_ena, in_iss_addr, in_clr_req,
    input  out_rd_data, out_rd_busy, out_clr_busy, out_clr_done
  );

  modport slave (
    input  in_rd_ena, in_rd_addr, in_wr_ena, in_wr_addr, in_wr_data,
    input  in_iss_ena, in_iss_addr, in_clr_req,
    output out_rd_data, out_rd_busy, out_clr_busy, out_clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with pending scoreboard and soft-clear sweep; reads have 1-cycle latency, no backpressure.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle writes/issues (including sweep clears) to the read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic          in_clk,
  input  logic          in_rst,
  regfile_mp_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [NRD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]        rd_busy_q, rd_busy_d;
  logic                  clr_busy_q, clr_busy_d;
  logic                  clr_done_q, clr_done_d;

  always_comb begin
    mem_d      = mem_q;
    pend_d     = pend_q;
    state_d    = state_q;
    idx_d      = idx_q;
    rd_data_d  = '0;
    rd_busy_d  = '0;

    case (state_q)
      ST_IDLE: begin
        // Ascending port order lets the highest-index port overwrite lower ones.
        for (int p = 0; p < NWR; p++) begin
          if (bus.in_wr_ena[p] && (bus.in_wr_addr[p*ADDR_W +: ADDR_W] != '0)) begin
            mem_d[bus.in_wr_addr[p*ADDR_W +: ADDR_W]]  = bus.in_wr_data[p*DATA_W +: DATA_W];
            pend_d[bus.in_wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
          end
        end
        // Issue after writes: a new producer outranks a retiring one.
        if (bus.in_iss_ena && (bus.in_iss_addr != '0)) begin
          pend_d[bus.in_iss_addr] = 1'b1;
        end
        if (bus.in_clr_req) begin
          state_d = ST_SWEEP;
          idx_d   = ADDR_W'(1);
        end
      end
      ST_SWEEP: begin
        mem_d[idx_q]  = '0;
        pend_d[idx_q] = 1'b0;
        if (idx_q == {ADDR_W{1'b1}}) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    clr_busy_d = (state_d == ST_SWEEP);
    clr_done_d = (state_d == ST_DONE);

    for (int k = 0; k < NRD; k++) begin
      if (bus.in_rd_ena[k] && (bus.in_rd_addr[k*ADDR_W +: ADDR_W] != '0)) begin
`ifdef REGFILE_MP_BYPASS_EN
        rd_data_d[k*DATA_W +: DATA_W] = mem_d[bus.in_rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy_d[k]                  = pend_d[bus.in_rd_addr[k*ADDR_W +: ADDR_W]];
`else
        rd_data_d[k*DATA_W +: DATA_W] = mem_q[bus.in_rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy_d[k]                  = pend_q[bus.in_rd_addr[k*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pend_q     <= '0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      rd_data_q  <= rd_data_d;
      rd_busy_q  <= rd_busy_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.out_rd_data  = rd_data_q;
  assign bus.out_rd_busy  = rd_busy_q;
  assign bus.out_clr_busy = clr_busy_q;
  assign bus.out_clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against a behavioural array model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;

  // Model: plain arrays plus one sweep position (0 idle, 1..DEPTH-1 sweeping, DEPTH done).
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] n_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            n_pend [DEPTH];
  int            m_pos;
  logic [DW-1:0] exp_data [NR];
  bit            exp_busy [NR];
  bit            exp_cbusy, exp_cdone;

  always @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
      for (int k = 0; k < NR; k++) begin exp_data[k] = '0; exp_busy[k] = 0; end
      m_pos = 0; exp_cbusy = 0; exp_cdone = 0;
    end else begin
      n_mem = m_mem; n_pend = m_pend;
      if (m_pos == 0) begin
        for (int p = 0; p < NW; p++) begin
          int a;
          a = int'(bus.in_wr_addr[p*AW +: AW]);
          if (bus.in_wr_ena[p] && a != 0) begin n_mem[a] = bus.in_wr_data[p*DW +: DW]; n_pend[a] = 0; end
        end
        if (bus.in_iss_ena && bus.in_iss_addr != 0) n_pend[int'(bus.in_iss_addr)] = 1;
        if (bus.in_clr_req) m_pos = 1;
      end else if (m_pos < DEPTH) begin
        n_mem[m_pos] = '0; n_pend[m_pos] = 0; m_pos = m_pos + 1;
      end else begin
        m_pos = 0;
      end
      for (int k = 0; k < NR; k++) begin
        int a;
        a = int'(bus.in_rd_addr[k*AW +: AW]);
        exp_data[k] = '0; exp_busy[k] = 0;
        if (bus.in_rd_ena[k] && a != 0) begin
`ifdef REGFILE_MP_BYPASS_EN
          exp_data[k] = n_mem[a]; exp_busy[k] = n_pend[a];
`else
          exp_data[k] = m_mem[a]; exp_busy[k] = m_pend[a];
`endif
        end
      end
      exp_cbusy = (m_pos >= 1 && m_pos < DEPTH);
      exp_cdone = (m_pos == DEPTH);
      m_mem = n_mem; m_pend = n_pend;
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge in_clk) begin
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("rd_data%0d", k), bus.out_rd_data[k*DW +: DW], exp_data[k]);
        chk($sformatf("rd_busy%0d", k), DW'(bus.out_rd_busy[k]), DW'(exp_busy[k]));
      end
      chk("clr_busy", DW'(bus.out_clr_busy), DW'(exp_cbusy));
      chk("clr_done", DW'(bus.out_clr_done), DW'(exp_cdone));
    end
  end

  task automatic cyc();
    @(posedge in_clk); #1;
  endtask

  task automatic clr_in();
    bus.in_rd_ena = '0; bus.in_rd_addr = '0; bus.in_wr_ena = '0; bus.in_wr_addr = '0;
    bus.in_wr_data = '0; bus.in_iss_ena = 0; bus.in_iss_addr = '0; bus.in_clr_req = 0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    bus.in_wr_ena[p] = 1'b1; bus.in_wr_addr[p*AW +: AW] = AW'(a); bus.in_wr_data[p*DW +: DW] = d;
  endtask

  task automatic rd(input int k, input int a);
    bus.in_rd_ena[k] = 1'b1; bus.in_rd_addr[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, waited;
    logic [DW-1:0] exp7, exp_r2;
    clr_in();
    repeat (3) @(posedge in_clk);
    #1 in_rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_data", bus.out_rd_data[DW-1:0], '0);

    // Write r5, then read it; write to r0 is dropped.
    wr(0, 5, 32'hDEADBEEF); cyc();
    clr_in(); rd(0, 5); wr(0, 0, 32'h1234); cyc();
    chk("r5_data", bus.out_rd_data[DW-1:0], 32'hDEADBEEF);
    chk("r5_busy", DW'(bus.out_rd_busy[0]), '0);
    clr_in(); rd(1, 0); cyc();
    chk("r0_data", bus.out_rd_data[DW +: DW], '0);

    // Port priority on r7.
    clr_in(); wr(0, 7, 32'h33); cyc();
    clr_in(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); cyc();
`ifdef REGFILE_MP_BYPASS_EN
    exp7 = 32'h22;
`else
    exp7 = 32'h33;
`endif
    chk("r7_same_cycle", bus.out_rd_data[DW-1:0], exp7);
    clr_in(); rd(0, 7); cyc();
    chk("r7_after", bus.out_rd_data[DW-1:0], 32'h22);

    // Scoreboard on r9.
    clr_in(); bus.in_iss_ena = 1; bus.in_iss_addr = 9; cyc();
    clr_in(); rd(0, 9); cyc();
    chk("r9_busy_issue", DW'(bus.out_rd_busy[0]), 1);
    clr_in(); wr(1, 9, 32'h5); cyc();
    clr_in(); rd(0, 9); cyc();
    chk("r9_busy_write", DW'(bus.out_rd_busy[0]), 0);
    chk("r9_data", bus.out_rd_data[DW-1:0], 32'h5);
    clr_in(); wr(0, 9, 32'h6); bus.in_iss_ena = 1; bus.in_iss_addr = 9; cyc();
    clr_in(); rd(1, 9); cyc();
    chk("r9_busy_both", DW'(bus.out_rd_busy[1]), 1);
    chk("r9_data2", bus.out_rd_data[DW +: DW], 32'h6);

    // Random traffic with dense address collisions and occasional sweeps.
    for (int c = 0; c < 600; c++) begin
      bus.in_rd_ena = NR'($urandom); bus.in_rd_addr = (NR*AW)'($urandom);
      bus.in_wr_ena = NW'($urandom); bus.in_wr_addr = (NW*AW)'($urandom);
      bus.in_wr_data = {$urandom, $urandom};
      bus.in_iss_ena = ($urandom_range(0, 2) == 0); bus.in_iss_addr = AW'($urandom);
      bus.in_clr_req = ($urandom_range(0, 79) == 0);
      cyc();
    end
    clr_in(); cyc();
    waited = 0;
    while ((bus.out_clr_busy || bus.out_clr_done) && waited < 64) begin cyc(); waited++; end
    chk("idle_before_fill", DW'(bus.out_clr_busy | bus.out_clr_done), 0);

    // Fill, sweep with writes attempted during it, then read back zeros.
    for (int a = 1; a < DEPTH; a++) begin
      clr_in(); wr(0, a, 32'h01010101 * a + 1); cyc();
    end
    clr_in(); bus.in_iss_ena = 1; bus.in_iss_addr = 3; bus.in_clr_req = 1; cyc();
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_clr_busy) busy_n++;
      if (bus.out_clr_done) done_n++;
      clr_in();
      if (done_n == 0) begin
        bus.in_wr_ena = NW'($urandom); bus.in_wr_addr = (NW*AW)'($urandom);
        bus.in_wr_data = {$urandom, $urandom};
        bus.in_iss_ena = 1; bus.in_iss_addr = AW'($urandom);
      end
      cyc();
    end
    chk("sweep_busy_cycles", DW'(busy_n), 31);
    chk("sweep_done_pulses", DW'(done_n), 1);
    for (int a = 0; a < DEPTH; a += 2) begin
      clr_in(); rd(0, a); rd(1, a + 1); cyc();
      chk("swept_data", bus.out_rd_data, '0);
      chk("swept_busy", DW'(bus.out_rd_busy), 0);
    end

    // Reset at sweep index 10, then a clean restart from index 1.
    clr_in(); bus.in_clr_req = 1; cyc();
    clr_in(); repeat (9) cyc();
    #2 in_rst = 1'b1;
    #1 chk("rst_mid_sweep_busy", DW'(bus.out_clr_busy), 0);
    @(posedge in_clk); @(posedge in_clk); #1 in_rst = 1'b0;
    done_n = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.out_clr_done) done_n++;
      cyc();
    end
    chk("no_done_after_rst", DW'(done_n), 0);
    clr_in(); wr(0, 1, 32'hAA); wr(1, 2, 32'hBB); cyc();
    clr_in(); bus.in_clr_req = 1; cyc();
    clr_in(); cyc();
    rd(0, 1); rd(1, 2); cyc();
`ifdef REGFILE_MP_BYPASS_EN
    exp_r2 = '0;
`else
    exp_r2 = 32'hBB;
`endif
    chk("restart_r1", bus.out_rd_data[DW-1:0], '0);
    chk("restart_r2", bus.out_rd_data[DW +: DW], exp_r2);
    clr_in();
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_clr_done) done_n++;
      cyc();
    end
    chk("restart_done", DW'(done_n), 1);

    // Asynchronous reset between clock edges.
    clr_in(); wr(0, 12, 32'h1234); cyc();
    clr_in(); rd(0, 12); bus.in_iss_ena = 1; bus.in_iss_addr = 12; cyc();
    chk("pre_rst_data", bus.out_rd_data[DW-1:0], 32'h1234);
    clr_in(); rd(0, 12); cyc();
    chk("pre_rst_busy", DW'(bus.out_rd_busy[0]), 1);
    #2 in_rst = 1'b1;
    #1 chk("async_rst_data", bus.out_rd_data[DW-1:0], '0);
    chk("async_rst_busy", DW'(bus.out_rd_busy[0]), 0);
    @(posedge in_clk); @(posedge in_clk); #1 in_rst = 1'b0;
    clr_in(); rd(0, 12); cyc();
    chk("post_rst_r12", bus.out_rd_data[DW-1:0], '0);
    clr_in(); cyc(); cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
